// File: rtl/gon_multicast_sender.sv
// GON multicast transmit end: sweeps receiver IDs through one-hot set_id strobes,
// then issues tagged packets on the shared bus, dropping any not accepted within TIMEOUT cycles.
`ifndef XID_BITS
`define XID_BITS 8
`endif

module gon_multicast_sender #(
  parameter int ID_SIZE    = `XID_BITS,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CTRL   = 8,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic [NUM_CTRL*ID_SIZE-1:0]  cfg_ids,
  output logic                         cfg_busy,
  output logic [NUM_CTRL-1:0]          set_id,
  output logic [ID_SIZE-1:0]           id_out,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ID_SIZE-1:0]           in_tag,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         valid_out,
  output logic [ID_SIZE-1:0]           tag,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         ready_in,
  output logic                         drop_pulse,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int KW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CTRL - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CFG, SEND} state_t;

  state_t                  state, state_nx;
  logic                    held;
  logic [ID_SIZE-1:0]      tag_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [TW-1:0]           timer;
  logic [KW-1:0]           k;
  logic                    drop_pulse_q;
  logic [CNT_WIDTH-1:0]    drop_count_q;
  logic                    load, accept, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // in_ready is gated by rst so it reads 0 while reset is asserted even though state is IDLE
  always_comb begin
    state_nx = state;
    cfg_busy = 1'b0;
    set_id   = '0;
    id_out   = '0;
    in_ready = 1'b0;
    load     = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst & ~cfg_start;
        if (cfg_start) state_nx = CFG;
        else if (in_valid) begin
          load     = 1'b1;
          state_nx = SEND;
        end
      end
      CFG: begin
        cfg_busy = 1'b1;
        set_id   = NUM_CTRL'(1) << k;
        id_out   = cfg_ids[k*ID_SIZE +: ID_SIZE];
        if (k == K_LAST) state_nx = IDLE;
      end
      SEND: begin
        if (ready_in) begin
          accept   = 1'b1;
          in_ready = rst;
          if (in_valid) load = 1'b1;
          else          state_nx = IDLE;
        end else if (timer == T_LAST) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held         <= 1'b0;
      tag_q        <= '0;
      data_q       <= '0;
      timer        <= '0;
      k            <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_pulse_q <= drop;
      if (drop && drop_count_q != '1) drop_count_q <= drop_count_q + 1'b1;
      if (state == CFG && k != K_LAST) k <= k + 1'b1;
      else                             k <= '0;
      if (load) begin
        held   <= 1'b1;
        tag_q  <= in_tag;
        data_q <= in_data;
        timer  <= '0;
      end else if (accept || drop) begin
        held  <= 1'b0;
        timer <= '0;
      end else if (held) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign valid_out  = held;
  assign tag        = tag_q;
  assign data_out   = data_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule
